paddle_step_encoder: RTL and testbench
======================================

# paddle_step_encoder

Transmit-side counterpart to the pong dip-switch decoder. It turns left/right step requests from game or test logic into a 3-position switch code (0, 1, 2) on `pos`, stepping in the direction the decoder interprets. Each code is held for a programmable dwell time, so a decoder clocked on the same clock sees every position. Bursts of requests are queued as a signed pending count. The block drives the decoder's `in_p` input, either in the FPGA bench or as the emulated paddle source.

## Interface
- `DWELL`, default 4: cycles each position is held before the next step; legal range 1..255.
- `MAXQ`, default 7: magnitude limit of the pending-step count; legal range 1..127.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `left_req` in 1: request one left step; level sampled every cycle, one step per high cycle.
- `right_req` in 1: request one right step; same sampling rule as `left_req`.
- `pos` out 3: switch code; always 0, 1 or 2.
- `busy` out 1: high while a step is in dwell or pending is non-zero.
- `step_pulse` out 1: one-cycle pulse in the cycle `pos` takes a new value.
- `step_dir` out 1: direction of the last step (1 = right, 0 = left); valid with `step_pulse` and held afterwards.
- `drop` out 1: one-cycle pulse when a request is discarded because pending is saturated.

## Operation
- Direction encoding:
  - Right step = `pos` increments mod 3: 0→1→2→0.
  - Left step = `pos` decrements mod 3: 0→2→1→0.
  - The 2→0 wrap is a right step; the 0→2 wrap is a left step.
- Pending count `pend` is a signed register in the range [-MAXQ, +MAXQ].
  - Each edge: `pend` ← `pend` + req_delta − launch_delta.
  - req_delta: +1 for `right_req` only, −1 for `left_req` only, 0 for both or neither. Simultaneous requests cancel, with no drop.
  - launch_delta: +1 when a right step launches, −1 when a left step launches.
  - If the result would exceed ±MAXQ, the request is discarded, `pend` keeps the launch-adjusted value, and `drop` pulses on the next cycle.
- The launch decision uses the registered `pend` only. A request arriving in the same cycle is never launched in that cycle.
- FSM states are IDLE and DWELL.
  - IDLE, `pend`≠0: launch a step in the sign of `pend`, load `cnt`←DWELL−1, go to DWELL.
  - IDLE, `pend`=0: stay in IDLE.
  - DWELL, `cnt`≠0: decrement `cnt`.
  - DWELL, `cnt`=0 and `pend`≠0: launch the next step, reload `cnt`, stay in DWELL.
  - DWELL, `cnt`=0 and `pend`=0: go to IDLE.
- A launch updates `pos`, `step_dir` and `step_pulse` on the same edge.
- `busy` = (state==DWELL) | (`pend`≠0). It is combinational from registers.
- Direction reversal while in dwell: `pend` changes sign. The next launch follows the new sign. A queued step is never reversed in mid-dwell.

## Timing
- Reset values: `pos`=0, `step_dir`=0, `step_pulse`=0, `drop`=0, `busy`=0, `pend`=0, state IDLE, `cnt`=0.
- Reset asserted mid-operation clears all of the above immediately and asynchronously. Pending steps are lost. Any spurious step the decoder sees when `pos` jumps to 0 is the system's responsibility.
- Latency from IDLE: a request first sampled at edge E0 changes `pos` at edge E1, and `step_pulse` is high during the cycle after E1.
- Back-to-back steps are exactly DWELL cycles apart (edge to edge) while `pend`≠0.
- After the last step, `busy` falls DWELL cycles after the final `pos` change.
- `drop` is high for exactly the one cycle after the edge that discarded the request.

## Test plan
- Reset, then 1-cycle `right_req` → `pos` 0→1 one edge after sampling; `step_pulse`=1 for one cycle with `step_dir`=1; `busy` falls 4 cycles after the `pos` change.
- `right_req` held 3 cycles, DWELL=4 → `pos` 1, 2, 0 at 4-cycle spacing (2→0 is a right wrap); `pend` peaks at 2.
- From `pos`=0, 2 left requests → `pos` 2 then 1, `step_dir`=0 on each step.
- `right_req` held 12 cycles with MAXQ=7 → `drop` pulses on the requests that exceed +7; exactly 7 steps plus launched steps are emitted, and none are lost below saturation.
- `left_req` and `right_req` high together for 5 cycles → no `pos` change, no `drop`, `busy` stays 0.
- 3 right requests, then `rst_n` low during the second dwell → `pos`=0, `busy`=0 asynchronously; no steps after release until a new request.

Source files
------------

// File: rtl/paddle_step_encoder.sv
// paddle_step_encoder: queues left/right step requests and emits a 3-position switch code with a fixed dwell per position
module paddle_step_encoder #(
  parameter int DWELL = 4,
  parameter int MAXQ  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left_req,
  input  logic       right_req,
  output logic [2:0] pos,
  output logic       busy,
  output logic       step_pulse,
  output logic       step_dir,
  output logic       drop
);
  typedef enum logic {S_IDLE, S_DWELL} state_t;
  localparam logic signed [8:0] LIM    = 9'(MAXQ);
  localparam logic        [7:0] RELOAD = 8'(DWELL - 1);
  state_t             r_state;
  logic         [7:0] r_cnt;
  logic signed  [8:0] r_pend;
  logic               w_launch;
  logic               w_right;
  logic               w_ovf;
  logic signed  [8:0] w_base;
  logic signed  [8:0] w_req;
  logic signed  [8:0] w_sum;
  assign w_launch = (r_pend != '0) && ((r_state == S_IDLE) || (r_cnt == '0));
  assign w_right  = ~r_pend[8];
  // launch is decided on the registered count only; this cycle's request lands on top
  assign w_base   = !w_launch ? r_pend : w_right ? r_pend - 9'sd1 : r_pend + 9'sd1;
  assign w_req    = (right_req & ~left_req) ? 9'sd1 : (left_req & ~right_req) ? -9'sd1 : 9'sd0;
  assign w_sum    = w_base + w_req;
  assign w_ovf    = (w_sum > LIM) || (w_sum < -LIM);
  assign busy     = (r_state == S_DWELL) || (r_pend != '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pend     <= '0;
      pos        <= '0;
      step_dir   <= 1'b0;
      step_pulse <= 1'b0;
      drop       <= 1'b0;
    end else begin
      r_pend     <= w_ovf ? w_base : w_sum;
      drop       <= w_ovf;
      step_pulse <= w_launch;
      if (w_launch) begin
        pos      <= w_right ? ((pos == 3'd2) ? 3'd0 : pos + 3'd1) : ((pos == 3'd0) ? 3'd2 : pos - 3'd1);
        step_dir <= w_right;
      end
      if (r_state == S_IDLE) begin
        if (w_launch) begin
          r_state <= S_DWELL;
          r_cnt   <= RELOAD;
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 8'd1;
      end else if (w_launch) begin
        r_cnt <= RELOAD;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_paddle_step_encoder.sv
// tb_paddle_step_encoder: vector table plus randomized run against a timestamp-based model, default and tight parameters
module tb_paddle_step_encoder;
  localparam int D0 = 4, Q0 = 7, D1 = 1, Q1 = 2;
  logic clk = 0, rst_n = 0, l = 0, r = 0;
  logic [2:0] pos0, pos1;
  logic busy0, busy1, pulse0, pulse1, dir0, dir1, drop0, drop1;
  logic [6:0] o0, o1;
  int passed = 0, total = 0, cyc = 0, n_step = 0, n_drop = 0;
  int m_pend[2], m_pos[2], m_last[2], m_dir[2], m_pulse[2], m_drop[2];

  typedef struct {bit l; bit r; int pos; bit busy; bit pulse; bit dir; bit drop;} vec_t;
  vec_t tbl[19];

  paddle_step_encoder #(.DWELL(D0), .MAXQ(Q0)) u0 (.clk(clk), .rst_n(rst_n), .left_req(l), .right_req(r),
    .pos(pos0), .busy(busy0), .step_pulse(pulse0), .step_dir(dir0), .drop(drop0));
  paddle_step_encoder #(.DWELL(D1), .MAXQ(Q1)) u1 (.clk(clk), .rst_n(rst_n), .left_req(l), .right_req(r),
    .pos(pos1), .busy(busy1), .step_pulse(pulse1), .step_dir(dir1), .drop(drop1));

  assign o0 = {pos0, busy0, pulse0, dir0, drop0};
  assign o1 = {pos1, busy1, pulse1, dir1, drop1};

  always #5 clk = ~clk;

  task automatic check(input string n, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s cyc=%0d got=%h expected=%h", n, cyc, act, exp);
    else passed++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_pos[i] = 0; m_last[i] = -1000;
      m_dir[i] = 0; m_pulse[i] = 0; m_drop[i] = 0;
    end
  endtask

  // a step may leave only once DWELL edges have passed since the previous one
  task automatic model_edge(input int i, input int dw, input int mq);
    int ld, base, sum;
    bit launch;
    launch = (m_pend[i] != 0) && (cyc - m_last[i] >= dw);
    ld = !launch ? 0 : (m_pend[i] > 0 ? 1 : -1);
    base = m_pend[i] - ld;
    sum = base + int'(r) - int'(l);
    m_drop[i] = (sum > mq) || (sum < -mq);
    m_pend[i] = m_drop[i] ? base : sum;
    m_pulse[i] = launch;
    if (launch) begin
      m_pos[i] = (m_pos[i] + ld + 3) % 3;
      m_dir[i] = (ld > 0);
      m_last[i] = cyc;
    end
  endtask

  function automatic int expv(input int i, input int dw);
    int b;
    b = (m_pend[i] != 0) || (cyc - m_last[i] < dw);
    return m_pos[i] * 16 + b * 8 + m_pulse[i] * 4 + m_dir[i] * 2 + m_drop[i];
  endfunction

  task automatic cycle(input bit li, input bit ri);
    l = li; r = ri;
    @(posedge clk);
    model_edge(0, D0, Q0);
    model_edge(1, D1, Q1);
    #1;
    check("model_d4", int'(o0), expv(0, D0));
    check("model_d1", int'(o1), expv(1, D1));
    n_step += int'(pulse0);
    n_drop += int'(drop0);
    cyc++;
  endtask

  initial begin
    tbl = '{
      '{0,1, 0,1,0,0,0}, '{0,0, 1,1,1,1,0}, '{0,0, 1,1,0,1,0}, '{0,0, 1,1,0,1,0},
      '{0,0, 1,1,0,1,0}, '{0,0, 1,0,0,1,0}, '{1,0, 1,1,0,1,0}, '{1,0, 0,1,1,0,0},
      '{0,0, 0,1,0,0,0}, '{0,0, 0,1,0,0,0}, '{0,0, 0,1,0,0,0}, '{0,0, 2,1,1,0,0},
      '{0,0, 2,1,0,0,0}, '{0,0, 2,1,0,0,0}, '{0,0, 2,1,0,0,0}, '{0,0, 2,0,0,0,0},
      '{1,1, 2,0,0,0,0}, '{1,1, 2,0,0,0,0}, '{1,1, 2,0,0,0,0}};
    model_reset();
    #12;
    check("reset_d4", int'(o0), 0);
    check("reset_d1", int'(o1), 0);
    @(negedge clk) rst_n = 1;

    foreach (tbl[k]) begin
      cycle(tbl[k].l, tbl[k].r);
      check($sformatf("vec%0d", k), int'(o0),
            tbl[k].pos * 16 + tbl[k].busy * 8 + tbl[k].pulse * 4 + tbl[k].dir * 2 + tbl[k].drop);
    end
    repeat (2) cycle(1, 1);

    n_step = 0; n_drop = 0;
    repeat (12) cycle(0, 1);
    for (int k = 0; k < 100 && o0[3]; k++) cycle(0, 0);
    check("sat_idle", int'(o0[3]), 0);
    check("sat_steps", n_step, 10);
    check("sat_drops", n_drop, 2);

    repeat (3) cycle(0, 1);
    repeat (4) cycle(0, 0);
    #2 rst_n = 0;
    #1;
    check("async_rst_d4", int'(o0), 0);
    check("async_rst_d1", int'(o1), 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    n_step = 0;
    repeat (10) cycle(0, 0);
    check("no_step_after_rst", n_step, 0);

    for (int k = 0; k < 600; k++) begin
      if (k < 200) cycle($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
      else if (k < 400) cycle($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
      else cycle($urandom_range(0, 1) != 0, $urandom_range(0, 7) == 0);
    end
    repeat (40) cycle(0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
